sensor_poll_scheduler: RTL and testbench

Sequences the board's sensor interface blocks once per periodic update tick. On each tick it walks the enabled sensors in fixed index order, and for each one it issues a start pulse and waits for done or a timeout. It then publishes a coherent snapshot of all readings with a per-sensor valid mask and a frame strobe for the display/UART side. It sits between the periodic update-pulse generator and the sensor drivers.

---
 rtl/env_sense_pkg.sv | 16 +
 rtl/sensor_poll_scheduler_poll_timeout.sv | 39 +++
 rtl/sensor_poll_scheduler.sv | 176 +++++++++++++++++
 tb/tb_sensor_poll_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/env_sense_pkg.sv
// Shared types and timing constants for the environmental sensing blocks.
package env_sense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        PUBLISH
    } poll_state_t;

    localparam int CLK_HZ                       = 50_000_000;
    localparam int DEFAULT_UPDATE_PERIOD_CYCLES = CLK_HZ;          // one update per second
    localparam int DEFAULT_TIMEOUT_CYCLES       = CLK_HZ / 10;     // 100 ms per sensor

endpackage

// File: rtl/sensor_poll_scheduler_poll_timeout.sv
// Clearable up-counter; expired is high while the count sits at TIMEOUT_CYCLES-1.
module poll_timeout
    import env_sense_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk50,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturates at the terminal count so it never wraps while the scheduler idles.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != TERMINAL) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == TERMINAL);

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Polls enabled sensors in index order once per tick and publishes a coherent
// snapshot of readings plus a per-sensor valid mask.
module sensor_poll_scheduler
    import env_sense_pkg::*;
#(
    parameter int NUM_SENSORS    = 3,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk50,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [NUM_SENSORS-1:0]        sensor_en,
    output logic [NUM_SENSORS-1:0]        sensor_start,
    input  logic [NUM_SENSORS-1:0]        sensor_done,
    input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data,
    output logic [NUM_SENSORS*DATA_W-1:0] result,
    output logic [NUM_SENSORS-1:0]        valid_mask,
    output logic                          frame_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int               IDX_W    = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SENSORS - 1);

    poll_state_t state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_SENSORS-1:0] en_q, en_d;
    logic [DATA_W-1:0]      shadow_q [NUM_SENSORS];
    logic [DATA_W-1:0]      shadow_d [NUM_SENSORS];
    logic [DATA_W-1:0]      data_slice [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] shadow_valid_q, shadow_valid_d;

    logic [NUM_SENSORS*DATA_W-1:0] shadow_flat_d;
    logic [NUM_SENSORS*DATA_W-1:0] result_q, result_d;
    logic [NUM_SENSORS-1:0]        valid_mask_q, valid_mask_d;
    logic [NUM_SENSORS-1:0]        next_sel;
    logic [NUM_SENSORS-1:0]        sensor_start_q, sensor_start_d;
    logic                          frame_valid_q, frame_valid_d;
    logic                          busy_q, busy_d;
    logic                          overrun_q, overrun_d;
    logic                          timeout_clear;
    logic                          timeout_expired;
    logic                          advance;

    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_slice
        assign data_slice[gi]                         = sensor_data[gi*DATA_W +: DATA_W];
        assign shadow_flat_d[gi*DATA_W +: DATA_W]     = shadow_d[gi];
        assign next_sel[gi]                           = (idx_d == IDX_W'(gi));
    end

    // Cleared on the edge into START so the count reads 0 during the start pulse.
    assign timeout_clear = (state_d == START);

    poll_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk50  (clk50),
        .reset  (reset),
        .clear  (timeout_clear),
        .expired(timeout_expired)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        en_d           = en_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        advance        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    en_d    = sensor_en;
                    idx_d   = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (en_q[idx_q]) begin
                    state_d = START;
                end else begin
                    shadow_valid_d[idx_q] = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = PUBLISH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (sensor_done[idx_q]) begin
                    shadow_d[idx_q]       = data_slice[idx_q];
                    shadow_valid_d[idx_q] = 1'b1;
                    advance               = 1'b1;
                end else if (timeout_expired) begin
                    shadow_valid_d[idx_q] = 1'b0;
                    advance               = 1'b1;
                end
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = PUBLISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SELECT;
                    end
                end
            end
            PUBLISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sensor_start_d = (state_d == START) ? next_sel : '0;
        frame_valid_d  = (state_d == PUBLISH);
        busy_d         = (state_d != IDLE);
        overrun_d      = tick && (state_q != IDLE);
        result_d       = result_q;
        valid_mask_d   = valid_mask_q;
        if (state_d == PUBLISH) begin
            result_d     = shadow_flat_d;
            valid_mask_d = shadow_valid_d;
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            en_q           <= '0;
            shadow_valid_q <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                shadow_q[i] <= '0;
            end
            result_q       <= '0;
            valid_mask_q   <= '0;
            sensor_start_q <= '0;
            frame_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            en_q           <= en_d;
            shadow_valid_q <= shadow_valid_d;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            result_q       <= result_d;
            valid_mask_q   <= valid_mask_d;
            sensor_start_q <= sensor_start_d;
            frame_valid_q  <= frame_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    assign sensor_start = sensor_start_q;
    assign result       = result_q;
    assign valid_mask   = valid_mask_q;
    assign frame_valid  = frame_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler: scoreboarded start order and frames,
// plus cycle-exact latency, timeout, overrun and asynchronous reset checks.
module tb_sensor_poll_scheduler;

    localparam int NS  = 3;
    localparam int DW  = 16;
    localparam int TMO = 20;

    logic            clk50 = 1'b0;
    logic            reset;
    logic            tick;
    logic [NS-1:0]   sensor_en;
    logic [NS-1:0]   sensor_start;
    logic [NS-1:0]   sensor_done;
    logic [NS*DW-1:0] sensor_data;
    logic [NS*DW-1:0] result;
    logic [NS-1:0]   valid_mask;
    logic            frame_valid;
    logic            busy;
    logic            overrun;

    logic [NS-1:0]   resp_done;
    logic [NS-1:0]   extra_done;
    assign sensor_done = resp_done | extra_done;

    sensor_poll_scheduler #(
        .NUM_SENSORS   (NS),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk50       (clk50),
        .reset       (reset),
        .tick        (tick),
        .sensor_en   (sensor_en),
        .sensor_start(sensor_start),
        .sensor_done (sensor_done),
        .sensor_data (sensor_data),
        .result      (result),
        .valid_mask  (valid_mask),
        .frame_valid (frame_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Responder configuration: done follows start after resp_delay cycles (0 = never).
    int          resp_delay [NS];
    logic [DW-1:0] resp_data [NS];
    int          resp_cnt [NS];

    // Reference model of the shadow registers and the expectation queues.
    logic [DW-1:0]    m_data [NS];
    logic [NS-1:0]    m_valid;
    int               exp_start_q [$];
    logic [NS*DW-1:0] exp_res_q [$];
    logic [NS-1:0]    exp_mask_q [$];

    int start_cyc [NS];
    int start_count   = 0;
    int frame_count   = 0;
    int frame_cyc     = 0;
    int overrun_count = 0;
    int overrun_cyc   = 0;
    int t_tick        = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk50);
        #1;
    endtask

    task automatic set_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        resp_data[0] = d0;
        resp_data[1] = d1;
        resp_data[2] = d2;
        sensor_data  = {d2, d1, d0};
    endtask

    task automatic do_tick(input logic [NS-1:0] en);
        logic [NS*DW-1:0] packed_res;
        step();
        sensor_en = en;
        tick      = 1'b1;
        t_tick    = cyc;
        for (int i = 0; i < NS; i++) begin
            if (!en[i]) begin
                m_valid[i] = 1'b0;
            end else begin
                exp_start_q.push_back(i);
                if (resp_delay[i] >= 1 && resp_delay[i] <= TMO - 1) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = resp_data[i];
                end else begin
                    m_valid[i] = 1'b0;
                end
            end
        end
        packed_res = {m_data[2], m_data[1], m_data[0]};
        exp_res_q.push_back(packed_res);
        exp_mask_q.push_back(m_valid);
        step();
        tick = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int n0;
        int k;
        n0 = frame_count;
        k  = 0;
        while (frame_count == n0 && k < budget) begin
            step();
            k++;
        end
        check("frame_seen", 64'(frame_count != n0), 64'd1);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    // Sensor model.
    initial begin
        resp_done = '0;
        for (int i = 0; i < NS; i++) resp_cnt[i] = 0;
        forever begin
            @(negedge clk50);
            resp_done = '0;
            for (int i = 0; i < NS; i++) begin
                if (resp_cnt[i] > 0) begin
                    resp_cnt[i]--;
                    if (resp_cnt[i] == 0) resp_done[i] = 1'b1;
                end
                if (sensor_start[i] && resp_delay[i] > 0) resp_cnt[i] = resp_delay[i];
            end
        end
    end

    // Output monitor: pops scoreboard entries on start pulses and frames.
    always @(negedge clk50) begin
        if (!reset) begin
            if (sensor_start != '0) begin
                int idx;
                idx = 0;
                for (int i = 0; i < NS; i++) if (sensor_start[i]) idx = i;
                check("start_onehot", 64'($onehot(sensor_start)), 64'd1);
                if (exp_start_q.size() == 0) begin
                    check("start_unexpected", 64'(sensor_start), 64'd0);
                end else begin
                    check("start_idx", 64'(idx), 64'(exp_start_q.pop_front()));
                end
                start_cyc[idx] = cyc;
                start_count++;
            end
            if (frame_valid) begin
                if (exp_res_q.size() == 0) begin
                    check("frame_unexpected", 64'(frame_valid), 64'd0);
                end else begin
                    check("frame_result", 64'(result), 64'(exp_res_q.pop_front()));
                    check("frame_mask", 64'(valid_mask), 64'(exp_mask_q.pop_front()));
                end
                frame_count++;
                frame_cyc = cyc;
            end
            if (overrun) begin
                overrun_count++;
                overrun_cyc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc0;
        int oc0;
        int fc0;
        int tx;

        reset      = 1'b1;
        tick       = 1'b0;
        sensor_en  = '0;
        extra_done = '0;
        m_valid    = '0;
        for (int i = 0; i < NS; i++) begin
            resp_delay[i] = 10;
            m_data[i]     = '0;
            start_cyc[i]  = 0;
        end
        set_data(16'h0011, 16'h0022, 16'h0033);

        repeat (3) step();
        check("rst_result", 64'(result), 64'd0);
        check("rst_mask", 64'(valid_mask), 64'd0);
        check("rst_outs", 64'({sensor_start, frame_valid, busy, overrun}), 64'd0);
        reset = 1'b0;
        repeat (2) step();

        // All three sensors answer after 10 cycles.
        do_tick(3'b111);
        check("busy_after_tick", 64'(busy), 64'd1);
        check("no_start_at_t1", 64'(sensor_start), 64'd0);
        wait_frame(100);
        check("t1_start0_lat", 64'(start_cyc[0]), 64'(t_tick + 2));
        check("t1_start_gap", 64'(start_cyc[1] - start_cyc[0]), 64'd12);
        check("t1_frame_lat", 64'(frame_cyc), 64'(t_tick + 37));
        check("t1_result", 64'(result), 64'h0033_0022_0011);
        check("t1_mask", 64'(valid_mask), 64'd7);
        step();
        check("t1_busy_done", 64'(busy), 64'd0);

        // Sensor 1 never answers.
        set_data(16'h0044, 16'h0055, 16'h0066);
        resp_delay[1] = 0;
        do_tick(3'b111);
        wait_frame(150);
        check("t2_timeout_gap", 64'(start_cyc[2] - start_cyc[1]), 64'(TMO + 1));
        check("t2_result", 64'(result), 64'h0066_0022_0044);
        check("t2_mask", 64'(valid_mask), 64'd5);

        // Only sensor 1 enabled.
        resp_delay[1] = 10;
        set_data(16'h0044, 16'h0077, 16'h0066);
        sc0 = start_count;
        do_tick(3'b010);
        wait_frame(100);
        check("t3_start_cnt", 64'(start_count - sc0), 64'd1);
        check("t3_frame_lat", 64'(frame_cyc), 64'(t_tick + 15));
        check("t3_mask", 64'(valid_mask), 64'd2);

        // Nothing enabled; a tick during PUBLISH is dropped.
        sc0 = start_count;
        oc0 = overrun_count;
        do_tick(3'b000);
        wait_until(t_tick + 4);
        check("t3b_frame_t4", 64'(frame_valid), 64'd1);
        check("t3b_mask", 64'(valid_mask), 64'd0);
        sensor_en = 3'b111;
        tick      = 1'b1;
        step();
        tick = 1'b0;
        check("t3b_overrun", 64'(overrun), 64'd1);
        check("t3b_busy_idle", 64'(busy), 64'd0);
        repeat (5) step();
        check("t3b_no_start", 64'(start_count - sc0), 64'd0);
        check("t3b_overrun_cnt", 64'(overrun_count - oc0), 64'd1);

        // Second tick while waiting on sensor 0.
        set_data(16'h0011, 16'h0022, 16'h0033);
        oc0 = overrun_count;
        fc0 = frame_count;
        do_tick(3'b111);
        wait_until(t_tick + 5);
        sensor_en = 3'b000;
        tick      = 1'b1;
        tx        = cyc;
        step();
        tick = 1'b0;
        check("t4_overrun", 64'(overrun), 64'd1);
        wait_frame(100);
        check("t4_overrun_cyc", 64'(overrun_cyc), 64'(tx + 1));
        check("t4_start_gap", 64'(start_cyc[1] - start_cyc[0]), 64'd12);
        check("t4_frame_lat", 64'(frame_cyc), 64'(t_tick + 37));
        repeat (10) step();
        check("t4_one_frame", 64'(frame_count - fc0), 64'd1);
        check("t4_overrun_cnt", 64'(overrun_count - oc0), 64'd1);

        // Stray done on sensor 2, then done[0] on the timeout cycle.
        resp_delay[0] = TMO - 1;
        resp_delay[2] = 3;
        set_data(16'hA0A0, 16'h0099, 16'hC0C0);
        do_tick(3'b101);
        wait_until(t_tick + 7);
        sensor_data[2*DW +: DW] = 16'h0BAD;
        extra_done = 3'b100;
        step();
        extra_done = '0;
        sensor_data[2*DW +: DW] = 16'hC0C0;
        wait_frame(100);
        check("t5_start_gap", 64'(start_cyc[2] - start_cyc[0]), 64'd22);
        check("t5_result", 64'(result), 64'hC0C0_0022_A0A0);
        check("t5_mask", 64'(valid_mask), 64'd5);

        // Asynchronous reset in the middle of WAIT.
        resp_delay[0] = 10;
        resp_delay[2] = 10;
        set_data(16'h1111, 16'h2222, 16'h3333);
        fc0 = frame_count;
        do_tick(3'b111);
        wait_until(t_tick + 5);
        #1 reset = 1'b1;
        #1;
        check("t6_async_result", 64'(result), 64'd0);
        check("t6_async_outs", 64'({valid_mask, sensor_start, frame_valid, busy}), 64'd0);
        exp_start_q.delete();
        exp_res_q.delete();
        exp_mask_q.delete();
        m_valid = '0;
        for (int i = 0; i < NS; i++) m_data[i] = '0;
        repeat (12) step();
        reset = 1'b0;
        repeat (2) step();
        check("t6_no_frame", 64'(frame_count - fc0), 64'd0);
        set_data(16'h0A0A, 16'h0B0B, 16'h0C0C);
        do_tick(3'b111);
        wait_frame(100);
        check("t6_restart_lat", 64'(start_cyc[0]), 64'(t_tick + 2));
        check("t6_frame_lat", 64'(frame_cyc), 64'(t_tick + 37));
        check("t6_result", 64'(result), 64'h0C0C_0B0B_0A0A);

        repeat (5) step();
        check("queues_drained", 64'(exp_res_q.size() + exp_start_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
